// File: rtl/udm_bus_arbiter.sv
// udm_bus_arbiter
//   Two-master, one-slave round-robin arbiter for the UDM req/ack/resp bus.
//   The granted master's request is forwarded to the slave. Each accepted read
//   pushes the issuing master's ID into an in-order FIFO. Every slave response
//   pops that FIFO and is steered back to the master that issued the read.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   m{0,1}_req_i/we_i/addr_bi/be_bi/wdata_bi   master request channel
//   m{0,1}_ack_o                  request accepted (combinational from bus_ack_i)
//   m{0,1}_resp_o/rdata_bo        read response (combinational from bus_resp_i)
//   bus_req_o/we_o/addr_bo/be_bo/wdata_bo      slave request channel
//   bus_ack_i, bus_resp_i, bus_rdata_bi        slave handshake and read data
//   err_o                         sticky: response arrived with no read outstanding
module udm_bus_arbiter #(
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,

  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_bo,
  output logic [3:0]  bus_be_bo,
  output logic [31:0] bus_wdata_bo,
  input  logic        bus_ack_i,
  input  logic        bus_resp_i,
  input  logic [31:0] bus_rdata_bi,

  output logic        err_o
);

  localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic               gnt_q;
  logic               prio_q;
  logic               err_q;

  logic               fifo_q [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;

  logic               sel_req, sel_we;
  logic [31:0]        sel_addr, sel_wdata;
  logic [3:0]         sel_be;
  logic               busy, fifo_full, fifo_empty;
  logic               accept, push, pop, head_id;

  // Granted master's request channel
  always_comb begin
    sel_req   = gnt_q ? m1_req_i    : m0_req_i;
    sel_we    = gnt_q ? m1_we_i     : m0_we_i;
    sel_addr  = gnt_q ? m1_addr_bi  : m0_addr_bi;
    sel_be    = gnt_q ? m1_be_bi    : m0_be_bi;
    sel_wdata = gnt_q ? m1_wdata_bi : m0_wdata_bi;
  end

  assign busy       = (state_q == BUSY);
  assign fifo_full  = (cnt_q == CNT_W'(RD_FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // A read is held back only while the ID FIFO cannot take its entry; writes
  // never need an entry and so always pass.
  assign bus_req_o    = busy && sel_req && !(!sel_we && fifo_full);
  assign bus_we_o     = busy && sel_we;
  assign bus_addr_bo  = busy ? sel_addr  : '0;
  assign bus_be_bo    = busy ? sel_be    : '0;
  assign bus_wdata_bo = busy ? sel_wdata : '0;

  assign accept   = bus_req_o && bus_ack_i;
  assign m0_ack_o = accept && !gnt_q;
  assign m1_ack_o = accept &&  gnt_q;

  assign push    = accept && !sel_we;
  assign pop     = bus_resp_i && !fifo_empty;
  assign head_id = fifo_q[rptr_q];

  assign m0_resp_o   = pop && !head_id;
  assign m1_resp_o   = pop &&  head_id;
  assign m0_rdata_bo = m0_resp_o ? bus_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? bus_rdata_bi : '0;

  assign err_o = err_q;

  // Arbitration FSM: IDLE picks a master, BUSY holds the grant until the
  // transfer is accepted or the granted master withdraws.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            state_q <= BUSY;
            gnt_q   <= (m0_req_i && m1_req_i) ? prio_q : m1_req_i;
          end
        end
        BUSY: begin
          if (accept) begin
            state_q <= IDLE;
            prio_q  <= ~gnt_q;
          end else if (!sel_req) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ID FIFO pointer/count next state. Pointers wrap naturally because the
  // depth is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (bus_resp_i && fifo_empty) err_q <= 1'b1;
    end
  end

  // Entry storage carries no reset; occupancy is governed by the counters.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= gnt_q;
  end

endmodule
